// File: rtl/dp_pkg.sv
// Shared types and constants for the sequenced datapath.
package dp_pkg;

  typedef enum logic [2:0] {
    OP_MOVI = 3'b000,
    OP_MOV  = 3'b001,
    OP_ADD  = 3'b010,
    OP_CMP  = 3'b011,
    OP_AND  = 3'b100,
    OP_MVN  = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  localparam int Z_BIT = 0;
  localparam int N_BIT = 1;
  localparam int V_BIT = 2;

  function automatic logic is_illegal(input op_e op);
    return (op == OP_ILL6) || (op == OP_ILL7);
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// Register file: one write port, a sequencer read port and a debug read port.
module dp_regfile #(
  parameter int W    = 16,
  parameter int NREG = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  logic [W-1:0] regs_q [NREG];
  logic [W-1:0] regs_d [NREG];

  // Next-state of the array: only the addressed entry changes on a write.
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  // Storage, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Both read ports are plain combinational lookups.
  always_comb begin
    rdata    = regs_q[raddr];
    dbg_data = regs_q[dbg_addr];
  end

endmodule

// File: rtl/datapath_seq.sv
// Datapath with register file, operand/result registers, shifter, ALU and
// status flags, driven by a small micro-sequencer.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | cmd_ready high; accept a command, MOVI loads C immediately
// LOAD_A  | A <= reg[rn]
// LOAD_B  | B <= reg[rm]
// EXEC    | C <= ALU(A, sh(B)); CMP updates the status flags
// WB      | response pulse; reg[rd] <= C unless CMP or illegal
module datapath_seq
  import dp_pkg::*;
#(
  parameter int W     = 16,
  parameter int NREG  = 8,
  parameter int IMM_W = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_rn,
  input  logic [AW-1:0]    cmd_rm,
  input  logic [1:0]       cmd_shift,
  input  logic [IMM_W-1:0] cmd_imm,
  output logic             rsp_valid,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_illegal,
  output logic [2:0]       status_out,
  output logic             busy,
  input  logic [AW-1:0]    dbg_addr,
  output logic [W-1:0]     dbg_data
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] rn_q, rn_d;
  logic [AW-1:0] rm_q, rm_d;
  logic [1:0]    shift_q, shift_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  c_q, c_d;
  logic [2:0]    status_q, status_d;

  logic          rf_we;
  logic [AW-1:0] rf_raddr;
  logic [W-1:0]  rf_rdata;

  logic [W-1:0]  sh_b;
  logic [W-1:0]  sub_res;
  logic [W-1:0]  alu_res;
  logic [W-1:0]  imm_ext;

  dp_regfile #(
    .W    (W),
    .NREG (NREG)
  ) u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (c_q),
    .raddr    (rf_raddr),
    .rdata    (rf_rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // The single sequencer read port serves rn in LOAD_A and rm otherwise.
  always_comb begin
    rf_raddr = (state_q == ST_LOAD_A) ? rn_q : rm_q;
  end

  // Shifter on the B operand, then the ALU.
  always_comb begin
    unique case (shift_q)
      SH_LSL1: sh_b = {b_q[W-2:0], 1'b0};
      SH_LSR1: sh_b = {1'b0, b_q[W-1:1]};
      SH_ASR1: sh_b = {b_q[W-1], b_q[W-1:1]};
      default: sh_b = b_q;
    endcase
    sub_res = a_q - sh_b;
    case (op_q)
      OP_MOV:  alu_res = sh_b;
      OP_MVN:  alu_res = ~sh_b;
      OP_ADD:  alu_res = a_q + sh_b;
      OP_AND:  alu_res = a_q & sh_b;
      OP_CMP:  alu_res = sub_res;
      default: alu_res = sh_b;
    endcase
    imm_ext = W'($signed(cmd_imm));
  end

  // Sequencer next-state, register loads and response outputs.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rn_d        = rn_q;
    rm_d        = rm_q;
    shift_d     = shift_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    status_d    = status_q;
    rf_we       = 1'b0;
    rsp_valid   = 1'b0;
    rsp_illegal = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          rd_d    = cmd_rd;
          rn_d    = cmd_rn;
          rm_d    = cmd_rm;
          shift_d = cmd_shift;
          case (op_e'(cmd_op))
            OP_MOVI: begin
              c_d     = imm_ext;
              state_d = ST_WB;
            end
            OP_MOV, OP_MVN:         state_d = ST_LOAD_B;
            OP_ADD, OP_AND, OP_CMP: state_d = ST_LOAD_A;
            default:                state_d = ST_WB;
          endcase
        end
      end
      ST_LOAD_A: begin
        a_d     = rf_rdata;
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        b_d     = rf_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        c_d = alu_res;
        if (op_q == OP_CMP) begin
          status_d[Z_BIT] = (sub_res == '0);
          status_d[N_BIT] = sub_res[W-1];
          status_d[V_BIT] = (a_q[W-1] != sh_b[W-1]) && (sub_res[W-1] != a_q[W-1]);
        end
        state_d = ST_WB;
      end
      ST_WB: begin
        rsp_valid   = 1'b1;
        rsp_illegal = is_illegal(op_q);
        rf_we       = !((op_q == OP_CMP) || is_illegal(op_q));
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MOVI;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      shift_q  <= SH_NONE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      shift_q  <= shift_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      status_q <= status_d;
    end
  end

  // Handshake and observation outputs.
  always_comb begin
    cmd_ready  = (state_q == ST_IDLE);
    busy       = !cmd_ready;
    rsp_result = c_q;
    status_out = status_q;
  end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
Parametrised successor of the lab datapath. It combines a register file, A/B operand registers, a shifter, an ALU, a result register C and a status register with a built-in micro-sequencer. One command is accepted per valid/ready handshake and executed over 1–4 cycles. Completion is reported with a single-cycle response pulse. It sits between the instruction decoder and the memory/PC logic of the RISC machine.

Parameters:
W, 16, datapath width in bits (>=4)
NREG, 8, number of registers (power of two, >=2)
IMM_W, 8, immediate width; sign-extended to W
AW, $clog2(NREG), register index width (derived, not overridable)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  high only in IDLE
cmd_op  input  3  opcode: 000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN, 110/111 illegal
cmd_rd  input  AW  destination register
cmd_rn  input  AW  A-operand register
cmd_rm  input  AW  B-operand register
cmd_shift  input  2  00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1 (sign fill)
cmd_imm  input  IMM_W  immediate for MOVI
rsp_valid  output  1  one-cycle completion pulse
rsp_result  output  W  C register value; valid while rsp_valid is high
rsp_illegal  output  1  qualified by rsp_valid
status_out  output  3  [0]=Z, [1]=N, [2]=V
busy  output  1  inverse of cmd_ready
dbg_addr  input  AW  debug read index
dbg_data  output  W  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (async assert, sync release):
  - all registers, A, B, C and status_out are 0
  - state is IDLE
  - rsp_valid and rsp_illegal are 0
- Reset mid-command aborts the command. No register write occurs.
- Command capture: the command fields are latched on the clk edge where cmd_valid && cmd_ready. cmd_valid while busy is ignored and not queued.
- States: IDLE, LOAD_A, LOAD_B, EXEC, WB.
- Transitions out of IDLE on accept:
  - MOVI → WB
  - MOV, MVN → LOAD_B
  - ADD, AND, CMP → LOAD_A
  - illegal → WB
- Fixed transitions: LOAD_A → LOAD_B → EXEC → WB → IDLE.
- State actions:
  - LOAD_A: A <= reg[rn].
  - LOAD_B: B <= reg[rm].
  - EXEC: the ALU computes and C <= result.
    - MOV: sh(B)
    - MVN: ~sh(B)
    - ADD: A+sh(B)
    - AND: A&sh(B)
    - CMP: A-sh(B)
  - MOVI: C <= sign-extended imm, loaded on the accept edge.
  - WB: rsp_valid=1 and rsp_result=C. reg[rd] <= C at the end of WB, except for CMP and illegal, which perform no write.
- Latency from the accept edge to the rsp_valid cycle:
  - MOVI: 1
  - MOV, MVN: 3
  - ADD, AND, CMP: 4
  - illegal: 1
- The next accept is possible in the cycle after WB. Back-to-back dependent commands therefore see the updated register (no forwarding needed).
- All arithmetic is modulo 2^W; the carry-out is discarded.
- Status flags:
  - Updated only by CMP, at the EXEC edge.
  - Z = (A-sh(B))==0.
  - N = result MSB.
  - V = signed overflow of subtraction: operands of different sign and result sign differing from A.
  - All other ops leave status_out unchanged.
- rsp_illegal=1 only in the WB of an illegal op. Neither registers nor status change.
- rd==rn or rd==rm is legal, because the operands are latched before WB.
- dbg_data reflects a write from the clock edge ending WB onward.

Decomposition:
- Package dp_pkg:
  - op_e enum with the codes above
  - state_e enum
  - shift code constants
  - status bit indices Z_BIT=0, N_BIT=1, V_BIT=2
- Sub-module dp_regfile (W, NREG):
  - one write port, two combinational read ports (sequencer and debug)
  - async active-low reset to 0
- The shifter and ALU stay inline as combinational logic in datapath_seq.

Test Plan:
1. Reset:
   - Stimulus: assert reset_n=0 mid-run, then release.
   - Response: dbg_data=0 for every address, status_out=000, cmd_ready=1, rsp_valid=0.
2. MOVI with negative immediate:
   - Stimulus: MOVI R0, imm=8'hFD.
   - Response: rsp_valid 1 cycle after accept, rsp_result=16'hFFFD, dbg R0=FFFD, status_out unchanged.
3. ADD with shifted operand:
   - Stimulus: MOVI R1,#7, then ADD R2,R1,R0 with LSL1.
   - Response: rsp at +4 cycles, result 16'h0001 (7+FFFA), R2=0001, status_out still 000.
4. CMP with overflow:
   - Stimulus: MOVI R4,#-1; MOV R5,R4 LSR1 (gives 7FFF); MOVI R6,#-1; CMP R5,R6.
   - Response: result 8000, status_out=110 (V=1, N=1, Z=0), R5 and R6 unchanged, no write to rd.
5. CMP of equal operands:
   - Stimulus: CMP R1,R1.
   - Response: status_out=001.
6. Illegal op, busy, and reset abort:
   - Stimulus: op=111 with rd=R1.
     Response: rsp_illegal=1 at +1 cycle, R1 unchanged.
   - Stimulus: hold cmd_valid during an ADD.
     Response: only one accept.
   - Stimulus: drop reset_n while in EXEC of ADD R3.
     Response: R3 stays 0, state returns to IDLE.
